// File: rtl/tlp_xcvr_pkg.sv
// Shared types and sizing constants for the TLP transceiver's CPU->FPGA pipe.
package tlp_xcvr_pkg;

    localparam int C2F_CHUNKSIZE_NBITS = 4;
    localparam int C2F_NUMCHUNKS_NBITS = 2;

    typedef logic [63:0] uint64;
    typedef logic [7:0]  ByteMask64;
    typedef logic [C2F_NUMCHUNKS_NBITS-1:0] C2FChunkIndex;
    typedef logic [C2F_CHUNKSIZE_NBITS-1:0] C2FChunkOffset;

    typedef struct packed {
        C2FChunkIndex  chunk;
        C2FChunkOffset offset;
    } C2FAddr;

endpackage

// File: rtl/c2f_ram.sv
// C2F chunk RAM: byte-enable write port, registered read port, no reset.
module c2f_ram
    import tlp_xcvr_pkg::*;
#(
    parameter int ADDR_W = C2F_CHUNKSIZE_NBITS + C2F_NUMCHUNKS_NBITS
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  ByteMask64         wr_mask,
    input  uint64             wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output uint64             rd_data
);

    uint64 mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read-before-write on a same-edge collision; the writer commits pointers later.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/c2f_consumer.sv
// Receive-side C2F consumer: owns the chunk RAM and streams committed chunks in order.
module c2f_consumer
    import tlp_xcvr_pkg::*;
#(
    parameter int CHUNK_QWS_LOG2  = C2F_CHUNKSIZE_NBITS,
    parameter int NUM_CHUNKS_LOG2 = C2F_NUMCHUNKS_NBITS
) (
    input  logic                       pcieClk_in,
    input  logic                       pcieRstn_in,
    input  logic                       c2fWriteEnable_in,
    input  logic [7:0]                 c2fByteMask_in,
    input  logic [NUM_CHUNKS_LOG2-1:0] c2fWrPtr_in,
    input  logic [CHUNK_QWS_LOG2-1:0]  c2fChunkOffset_in,
    input  logic [63:0]                c2fData_in,
    output logic [63:0]                c2fData_out,
    output logic                       c2fValid_out,
    input  logic                       c2fReady_in,
    output logic                       c2fLast_out,
    output logic [NUM_CHUNKS_LOG2-1:0] c2fRdPtr_out,
    output logic                       c2fEmpty_out
);

    // Stream handshake: a beat transfers on a rising edge where c2fValid_out && c2fReady_in;
    // once valid is raised, data/last hold until that transfer happens.

    localparam int ADDR_W = CHUNK_QWS_LOG2 + NUM_CHUNKS_LOG2;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [CHUNK_QWS_LOG2-1:0] LAST_OFFSET = '1;

    logic [1:0]                 state;
    logic [NUM_CHUNKS_LOG2-1:0] rd_ptr;
    logic [NUM_CHUNKS_LOG2-1:0] next_ptr;
    logic [NUM_CHUNKS_LOG2-1:0] issue_chunk;
    logic [CHUNK_QWS_LOG2-1:0]  rd_offset;
    logic                       pend;
    logic                       pend_last;
    uint64                      ram_q;
    logic                       out_valid;
    logic                       out_last;
    uint64                      out_data;
    logic                       skid_valid;
    logic                       skid_last;
    uint64                      skid_data;
    logic                       pop;
    logic                       final_pop;
    logic                       avail;
    logic                       next_avail;
    logic [1:0]                 fill_after;
    logic                       room;
    logic                       issue;

    c2f_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (pcieClk_in),
        .wr_en   (c2fWriteEnable_in),
        .wr_addr ({c2fWrPtr_in, c2fChunkOffset_in}),
        .wr_mask (c2fByteMask_in),
        .wr_data (c2fData_in),
        .rd_en   (issue),
        .rd_addr ({issue_chunk, rd_offset}),
        .rd_data (ram_q)
    );

    assign next_ptr   = rd_ptr + 1'b1;
    assign avail      = (rd_ptr != c2fWrPtr_in);
    assign next_avail = (next_ptr != c2fWrPtr_in);
    assign pop        = out_valid && c2fReady_in;
    assign final_pop  = pop && out_last;

    // Entries held after this edge, crediting this cycle's pop; keeps buffer + in-flight <= 2.
    assign fill_after = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, pend} - {1'b0, pop};
    assign room       = (fill_after < 2'd2);

    // IDLE and the final accept in DRAIN issue offset 0 directly to save a cycle of latency.
    always_comb begin
        issue       = 1'b0;
        issue_chunk = rd_ptr;
        case (state)
            S_IDLE:   issue = avail && room;
            S_STREAM: issue = room;
            S_DRAIN: begin
                issue       = final_pop && next_avail && room;
                issue_chunk = next_ptr;
            end
            default:  issue = 1'b0;
        endcase
    end

    always_ff @(posedge pcieClk_in or negedge pcieRstn_in) begin
        if (!pcieRstn_in) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            rd_offset <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            pend      <= issue;
            pend_last <= issue && (rd_offset == LAST_OFFSET);
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        rd_offset <= rd_offset + 1'b1;
                        state     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (issue) begin
                        rd_offset <= rd_offset + 1'b1;
                        if (rd_offset == LAST_OFFSET) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (final_pop) begin
                        rd_ptr <= next_ptr;
                        if (issue) begin
                            rd_offset <= rd_offset + 1'b1;
                            state     <= S_STREAM;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register plus skid; the skid only fills while the output register is stalled.
    always_ff @(posedge pcieClk_in or negedge pcieRstn_in) begin
        if (!pcieRstn_in) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || c2fReady_in) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_last   <= skid_last;
                out_data   <= skid_data;
                skid_valid <= pend;
                skid_last  <= pend_last;
                skid_data  <= ram_q;
            end else begin
                out_valid <= pend;
                out_last  <= pend_last;
                out_data  <= ram_q;
            end
        end else if (pend) begin
            skid_valid <= 1'b1;
            skid_last  <= pend_last;
            skid_data  <= ram_q;
        end
    end

    assign c2fData_out  = out_data;
    assign c2fValid_out = out_valid;
    assign c2fLast_out  = out_valid && out_last;
    assign c2fRdPtr_out = rd_ptr;
    assign c2fEmpty_out = (rd_ptr == c2fWrPtr_in);

endmodule

// File: tb/tb_c2f_consumer.sv
// Randomized scoreboard bench for c2f_consumer against a chunk-ring memory model.
module tb_c2f_consumer;
    import tlp_xcvr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [7:0]  mask;
    logic [1:0]  wr_ptr;
    logic [3:0]  off;
    logic [63:0] wdata;
    logic [63:0] data_o;
    logic        valid_o;
    logic        ready;
    logic        last_o;
    logic [1:0]  rd_ptr_o;
    logic        empty_o;

    // Model: what the RAM holds, the beats owed to the consumer, and the consumed pointer.
    logic [63:0] model_mem [4][16];
    logic [64:0] exp_q [$];
    logic [1:0]  exp_rd_ptr = 2'd0;

    int n_checks = 0;
    int n_pass = 0;
    int beats_seen = 0;
    int unexpected_cnt = 0;
    int ready_pct = 100;

    logic        ptr_chk_pending = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last;
    logic [64:0] mon_e;

    c2f_consumer dut (
        .pcieClk_in        (clk),
        .pcieRstn_in       (rst_n),
        .c2fWriteEnable_in (we),
        .c2fByteMask_in    (mask),
        .c2fWrPtr_in       (wr_ptr),
        .c2fChunkOffset_in (off),
        .c2fData_in        (wdata),
        .c2fData_out       (data_o),
        .c2fValid_out      (valid_o),
        .c2fReady_in       (ready),
        .c2fLast_out       (last_o),
        .c2fRdPtr_out      (rd_ptr_o),
        .c2fEmpty_out      (empty_o)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    initial begin
        ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor: pops the scoreboard on every accepted beat, checks stalls and pointer updates.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("valid_in_reset", valid_o, 1'b0);
            ptr_chk_pending = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (ptr_chk_pending) begin
                check("rd_ptr_after_chunk", rd_ptr_o, exp_rd_ptr);
                ptr_chk_pending = 1'b0;
            end
            if (prev_stall) begin
                check("stall_valid", valid_o, 1'b1);
                check("stall_data", data_o, prev_data);
                check("stall_last", last_o, prev_last);
            end
            if (valid_o && ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    unexpected_cnt++;
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", data_o, mon_e[63:0]);
                    check("beat_last", last_o, mon_e[64]);
                    if (mon_e[64]) begin
                        exp_rd_ptr = exp_rd_ptr + 2'd1;
                        ptr_chk_pending = 1'b1;
                    end
                end
            end
            prev_stall = valid_o && !ready;
            prev_data  = data_o;
            prev_last  = last_o;
        end
    end

    task automatic write_qw(input logic [3:0] o, input logic [63:0] d, input logic [7:0] m);
        we = 1'b1;
        off = o;
        wdata = d;
        mask = m;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) model_mem[wr_ptr][o][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic fill_chunk(input logic [63:0] base, input bit rand_data);
        for (int i = 0; i < 16; i++) begin
            write_qw(4'(i), rand_data ? {$urandom, $urandom} : base + 64'(i), 8'hFF);
        end
    endtask

    task automatic commit(input logic [1:0] new_ptr);
        for (int c = int'(wr_ptr); c != int'(new_ptr); c = (c + 1) % 4) begin
            for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), model_mem[c][i]});
        end
        wr_ptr = new_ptr;
    endtask

    task automatic wait_room();
        int cnt = 0;
        while (((wr_ptr + 2'd1) == exp_rd_ptr) && cnt < 3000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("ring_room_wait", (cnt < 3000), 1'b1);
    endtask

    task automatic wait_drain();
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < 5000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_ptr = 2'd0;
        exp_q.delete();
        exp_rd_ptr = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int cyc;
        int acc;
        int b0;
        rst_n = 1'b0;
        we = 1'b0;
        mask = 8'h00;
        wr_ptr = 2'd0;
        off = 4'd0;
        wdata = 64'd0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_valid", valid_o, 1'b0);
        check("reset_last", last_o, 1'b0);
        check("reset_rd_ptr", rd_ptr_o, 2'd0);
        check("reset_empty", empty_o, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single chunk with first-beat latency
        fill_chunk(64'h1000, 1'b0);
        @(posedge clk);
        #1;
        commit(2'd1);
        n = 0;
        while (!valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_valid_latency", n, 3);
        @(posedge clk);
        #1;
        wait_drain();
        check("single_rd_ptr", rd_ptr_o, 2'd1);
        check("single_empty", empty_o, 1'b1);

        // Byte masks on QW0 of chunk 1
        write_qw(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        write_qw(4'd0, 64'h0, 8'h0F);
        for (int i = 1; i < 16; i++) write_qw(4'(i), {$urandom, $urandom}, 8'(1 << (i % 8)) | 8'hF0);
        wait_room();
        commit(2'd2);
        wait_drain();

        // Backpressure across 4 chunks
        ready_pct = 30;
        for (int k = 0; k < 4; k++) begin
            fill_chunk(64'd0, 1'b1);
            wait_room();
            commit(wr_ptr + 2'd1);
        end
        wait_drain();
        check("bp_empty", empty_o, 1'b1);

        // Wrap: 6 chunks through the ring
        do_reset();
        ready_pct = 70;
        for (int k = 0; k < 6; k++) begin
            fill_chunk(64'd0, 1'b1);
            wait_room();
            commit(wr_ptr + 2'd1);
        end
        wait_drain();
        check("wrap_rd_ptr", rd_ptr_o, 2'd2);
        ready_pct = 100;

        // Back-to-back: pointer jumps 0 -> 3 in one step
        do_reset();
        fill_chunk(64'd0, 1'b1);
        @(posedge clk);
        #1;
        commit(2'd3);
        n = 0;
        while (!valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        cyc = 0;
        acc = 0;
        do begin
            if (valid_o && ready) acc++;
            cyc++;
            if (acc < 48) @(negedge clk);
        end while (acc < 48 && cyc < 300);
        check("b2b_beats", acc, 48);
        check("b2b_cycles_le_50", (cyc <= 50), 1'b1);
        @(posedge clk);
        #1;
        wait_drain();
        check("b2b_rd_ptr", rd_ptr_o, 2'd3);

        // Reset at beat 7 of a chunk
        do_reset();
        fill_chunk(64'd0, 1'b1);
        commit(2'd1);
        b0 = beats_seen;
        n = 0;
        while (beats_seen < b0 + 7 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_beat7", (n < 200), 1'b1);
        rst_n = 1'b0;
        wr_ptr = 2'd0;
        exp_q.delete();
        exp_rd_ptr = 2'd0;
        @(negedge clk);
        check("mid_reset_valid", valid_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_rd_ptr", rd_ptr_o, 2'd0);
        check("post_reset_empty", empty_o, 1'b1);
        check("post_reset_valid", valid_o, 1'b0);

        check("unexpected_beats", unexpected_cnt, 0);
        check("exp_q_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/c2f_consumer.md
# c2f_consumer

Receive-side consumer of the memory-mapped CPU->FPGA pipe. It owns the C2F chunk RAM and accepts the byte-masked QW writes produced by `tlp_recv`. It also tracks the CPU-committed write pointer and streams each committed chunk, in order, to FPGA application logic over a 64-bit valid/ready interface. A registered read pointer is published so the register path can report consumed chunks back to the CPU.

## Interface
Parameters:
- `CHUNK_QWS_LOG2`, default `tlp_xcvr_pkg::C2F_CHUNKSIZE_NBITS` (4): log2 of QWs per chunk; must equal the width of `C2FChunkOffset`.
- `NUM_CHUNKS_LOG2`, default `tlp_xcvr_pkg::C2F_NUMCHUNKS_NBITS` (2): log2 of chunks in the ring; must equal the width of `C2FChunkIndex`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `pcieClk_in`, in, 1: 125MHz core clock; all logic is on its rising edge.
  - `pcieRstn_in`, in, 1: asynchronous assert, synchronous deassert, active-low.
- Write port, driven by `tlp_recv`:
  - `c2fWriteEnable_in`, in, 1: write strobe.
  - `c2fByteMask_in`, in, 8: per-byte write enable; bit i covers `data[8i+7:8i]`.
  - `c2fWrPtr_in`, in, `NUM_CHUNKS_LOG2`: CPU-committed write pointer; also selects the chunk being written.
  - `c2fChunkOffset_in`, in, `CHUNK_QWS_LOG2`: QW offset within the chunk.
  - `c2fData_in`, in, 64: write data.
- Application stream:
  - `c2fData_out`, out, 64: chunk data.
  - `c2fValid_out`, out, 1: data valid.
  - `c2fReady_in`, in, 1: consumer ready.
  - `c2fLast_out`, out, 1: marks the final QW of a chunk.
- Pointer and status:
  - `c2fRdPtr_out`, out, `NUM_CHUNKS_LOG2`: index of the next chunk to consume.
  - `c2fEmpty_out`, out, 1: high when `c2fRdPtr_out == c2fWrPtr_in`.

## Operation
- RAM write:
  - When `c2fWriteEnable_in` is high, write RAM address {`c2fWrPtr_in`, `c2fChunkOffset_in`}.
  - Only bytes whose `c2fByteMask_in` bit is set are written; masked bytes keep their old value.
- Availability:
  - A chunk is available when `rdPtr != c2fWrPtr_in`. Any nonzero modular difference counts as available; pointer subtraction wraps modulo 2^`NUM_CHUNKS_LOG2`.
  - Ring-full is governed by CPU protocol: the CPU never writes chunk `rdPtr`. A write that violates this corrupts stream data but must not corrupt the pointers or the FSM.
- Read FSM:
  - S_IDLE: `rdOffset` = 0. When a chunk is available, go to S_STREAM.
  - S_STREAM:
    - Issue a RAM read at {`rdPtr`, `rdOffset`} whenever the output buffer has room (occupancy + in-flight < 2). `rdOffset` increments on each issued read.
    - After issuing offset 2^`CHUNK_QWS_LOG2`-1, stop issuing and go to S_DRAIN.
  - S_DRAIN: wait for the accept of the QW flagged last. On that accept, `rdPtr` increments (wrapping). Then go to S_STREAM if another chunk is available, otherwise S_IDLE. The next chunk may start issuing in the cycle after the accept.
- Output buffer:
  - 2-entry buffer (output register plus skid) carrying {data, last}.
  - A beat is accepted when `c2fValid_out && c2fReady_in`.
  - No beat is dropped or duplicated under any `c2fReady_in` pattern.
- `c2fLast_out` is high only on offset 2^`CHUNK_QWS_LOG2`-1.

## Timing
- Reset values: `c2fValid_out`=0, `c2fLast_out`=0, `c2fRdPtr_out`=0, `c2fEmpty_out` follows `c2fWrPtr_in`==0, FSM=S_IDLE, `rdOffset`=0. `c2fData_out` is don't-care while not valid.
- RAM: simple dual-port, registered read, 1-cycle latency.
- Latency:
  - `c2fWrPtr_in` advances at edge t, from empty, with `c2fReady_in` held high: first `c2fValid_out` high after edge t+2.
  - With `c2fReady_in` held high, the stream is one QW per cycle with no bubbles within a chunk and at most 1 bubble between chunks.
- Write-to-read: a RAM write at edge t is visible to reads issued at t+1 or later. `tlp_recv` commits the pointer only after the data writes, so ordering is guaranteed.
- Stall: while `c2fValid_out` is high and `c2fReady_in` is low, `c2fData_out` and `c2fLast_out` hold stable.
- `c2fRdPtr_out` is registered and updates the cycle after the final accept.
- Simultaneous final accept and `c2fWrPtr_in` change: both take effect; availability uses the updated `rdPtr` next cycle.
- Reset mid-chunk: buffered and in-flight beats are discarded, `rdPtr` returns to 0, RAM contents are not cleared. The system resets `tlp_recv` pointer state with the same event.

## Structure
- `tlp_xcvr_pkg`: reuse `uint64`, `ByteMask64`, `C2FChunkIndex`, `C2FChunkOffset`; add `C2FAddr` = {`C2FChunkIndex`, `C2FChunkOffset`} and the two size constants.
- Sub-module `c2f_ram`: byte-enable write port, registered read port, no reset, inferred block RAM.
- The FSM, `rdPtr`, `rdOffset` and the 2-entry output buffer stay in `c2f_consumer`.

## Test plan
- Single chunk: write 16 QWs of value 0x1000+i to chunk 0, then set wrPtr=1. Expect 16 beats 0x1000..0x100F, last only on beat 15, `c2fRdPtr_out`=1, `c2fEmpty_out`=1.
- Byte masks: pre-fill QW0 with 0xFFFF_FFFF_FFFF_FFFF, then write 0 with mask 0x0F. Expect readback 0xFFFF_FFFF_0000_0000.
- Backpressure: `c2fReady_in` random at 30% across 4 chunks. Expect 64 beats in order, no drop or duplicate, stable data while stalled.
- Wrap: stream 6 chunks through the 4-chunk ring with wrPtr 1,2,3,0,1,2. Expect `c2fRdPtr_out` sequence 1,2,3,0,1,2 and correct data.
- Back-to-back: wrPtr jumps 0->3 in one cycle with ready high. Expect 48 consecutive beats with at most 1 idle cycle between chunks.
- Reset at beat 7 of a chunk: expect valid 0 during reset, `c2fRdPtr_out`=0 afterwards, and no stale beat emitted.
